pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised program counter for the CPU datapath.
- Supports increment, absolute jump, subroutine call and return through an internal return-address stack (RAS), with a configurable reset vector.
- Sits between the control FSM (supplies `en`/`op`) and the bus (supplies `target`); `pc` drives instruction fetch address.
- Stack misuse is flagged by a sticky fault bit that the control unit reads.

Parameters:
- WIDTH, 16: address width of `pc`, `target` and stack entries.
- DEPTH, 8: RAS entries; must be ≥2; pointer width `$clog2(DEPTH+1)`.
- RESET_VECTOR, 0: value loaded into `pc` on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance enable; when 0, all state holds.
- op  in  3  operation: 0 INC, 1 JUMP, 2 CALL, 3 RET, 4 REL (optional), 5-7 reserved.
- target  in  WIDTH  jump/call address, or signed offset for REL.
- clr_fault  in  1  synchronous clear of `fault`.
- pc  out  WIDTH  current program counter (registered).
- ret_addr  out  WIDTH  top-of-stack entry; 0 when stack is empty.
- sp  out  clog2(DEPTH+1)  number of valid stack entries.
- stack_full  out  1  sp == DEPTH.
- stack_empty  out  1  sp == 0.
- fault  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (async): `pc`=RESET_VECTOR, `sp`=0, `fault`=0, `stack_empty`=1, `stack_full`=0, `ret_addr`=0. Stack RAM contents are don't-care.
- All updates occur on rising `clk` with `en`=1; latency is 1 cycle, so new `pc` is visible after the edge. With `en`=0, every register holds and `clr_fault` is still honoured.
- INC: `pc` <= `pc`+1 mod 2^WIDTH. 0xFFFF wraps to 0x0000 with no flag.
- JUMP: `pc` <= `target`.
- CALL, `sp`<DEPTH: stack[`sp`] <= `pc`+1 (wrapped), `sp` <= `sp`+1, `pc` <= `target`.
- CALL, `sp`==DEPTH (overflow): no push, `pc` holds, `fault` <= 1.
- RET, `sp`>0: `pc` <= stack[`sp`-1], `sp` <= `sp`-1.
- RET, `sp`==0 (underflow): `pc` holds, `fault` <= 1.
- Reserved ops (5-7, and 4 when REL is compiled out): behave as INC.
- `fault` priority: a set in the same cycle as `clr_fault` wins, leaving `fault`=1. Otherwise `clr_fault`=1 clears `fault` to 0.
- `ret_addr`, `stack_full`, `stack_empty` are combinational from `sp` and the stack array, and track `sp` within the same cycle.
- Reset asserted mid-sequence (e.g. with `sp`=3) returns immediately to the reset state. The stack is logically emptied.
- Exactly one op executes per enabled cycle. There is no pipelining and no bypass between consecutive CALL/RET; back-to-back CALL then RET returns the pushed address on the next cycle.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined: op 4 (REL) sets `pc` <= `pc` + 1 + signed(`target`), modulo 2^WIDTH. `target` is interpreted as two's-complement WIDTH-bit. REL does not touch the stack or `fault`.
- Undefined: op 4 behaves exactly as INC. No adder for the offset path is synthesised.

Test Plan (WIDTH=16, DEPTH=4, RESET_VECTOR=0x0100):
- Reset, then 3 cycles of INC with `en`=1 -> `pc` = 0x0101, 0x0102, 0x0103; `sp`=0, `stack_empty`=1. One cycle with `en`=0 -> `pc` stays 0x0103.
- `pc`=0xFFFF, INC -> `pc`=0x0000, `fault`=0. JUMP with `target`=0x1234 -> `pc`=0x1234.
- From `pc`=0x0010: CALL 0x0200, CALL 0x0300 -> `pc`=0x0300, `sp`=2, `ret_addr`=0x0201. RET -> `pc`=0x0201, `sp`=1. RET -> `pc`=0x0011, `sp`=0, `stack_empty`=1.
- Four CALLs fill the stack (`stack_full`=1). A fifth CALL 0x0800 -> `pc` unchanged, `sp`=4, `fault`=1. Assert `clr_fault` and RET in the same cycle -> `fault`=0 and the pop occurs.
- With `sp`=0, RET while `clr_fault`=1 -> `fault`=1 (set wins), `pc` unchanged. Assert `rst` mid-cycle with `sp`=3 -> `pc`=0x0100, `sp`=0, `fault`=0 without waiting for a clock edge.
- PC_REL_BRANCH_EN defined, `pc`=0x0050: REL `target`=0xFFF0 (-16) -> `pc`=0x0041. Macro undefined, same stimulus -> `pc`=0x0051.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with an internal return-address stack and a sticky stack-misuse fault.
// Optional relative branch on op 4 is compiled in when PC_REL_BRANCH_EN is defined.
module pc_stack_unit #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             target,
  input  logic                         clr_fault,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             ret_addr,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         fault
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_JUMP = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_REL  = 3'd4
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    sp_q, sp_d;
  logic             fault_q, fault_d;
  logic             fault_set;
  logic             push;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign pc_inc   = pc_q + WIDTH'(1);
  assign push_idx = AW'(sp_q);
  assign top_idx  = AW'(sp_q - PW'(1));

  assign stack_full  = (sp_q == PW'(DEPTH));
  assign stack_empty = (sp_q == '0);
  // Empty stack reads as zero rather than whatever stale entry sits below sp.
  assign ret_addr    = stack_empty ? '0 : stack_q[top_idx];

  assign pc    = pc_q;
  assign sp    = sp_q;
  assign fault = fault_q;

  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    push      = 1'b0;
    fault_set = 1'b0;
    if (en) begin
      case (op)
        OP_INC:  pc_d = pc_inc;
        OP_JUMP: pc_d = target;
        OP_CALL: begin
          if (stack_full) begin
            fault_set = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + PW'(1);
            pc_d = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            fault_set = 1'b1;
          end else begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - PW'(1);
          end
        end
`ifdef PC_REL_BRANCH_EN
        OP_REL:  pc_d = pc_inc + target;
`endif
        default: pc_d = pc_inc;
      endcase
    end
    // A fault raised this cycle beats a simultaneous clear; clear works even when en is low.
    if (fault_set) begin
      fault_d = 1'b1;
    end else if (clr_fault) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  // Entries are only meaningful below sp, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomized scoreboard bench for pc_stack_unit (WIDTH=16, DEPTH=4, RESET_VECTOR=0x0100)
// with a queue-based reference model; directed test-plan sequences run first.
module tb_pc_stack_unit;

  localparam int EW = 38;
  localparam logic [15:0] RV = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [15:0] target;
  logic        clr_fault;
  logic [15:0] pc;
  logic [15:0] ret_addr;
  logic [2:0]  sp;
  logic        stack_full;
  logic        stack_empty;
  logic        fault;

  pc_stack_unit #(.WIDTH(16), .DEPTH(4), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .clr_fault(clr_fault),
    .pc(pc), .ret_addr(ret_addr), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .fault(fault)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stack is a plain queue of return addresses.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_fault;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic logic [EW-1:0] snapshot();
    logic [15:0] top;
    top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 16'h0000;
    return {m_pc, 3'(m_ras.size()), m_fault, top,
            (m_ras.size() == 4), (m_ras.size() == 0)};
  endfunction

  task automatic model_reset();
    m_pc = RV;
    m_ras.delete();
    m_fault = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [2:0] o,
                            input logic [15:0] t, input logic c);
    logic set;
    int   off;
    set = 1'b0;
    if (e) begin
      case (o)
        3'd1: m_pc = t;
        3'd2: begin
          if (m_ras.size() == 4) set = 1'b1;
          else begin
            m_ras.push_back(16'((int'(m_pc) + 1) % 65536));
            m_pc = t;
          end
        end
        3'd3: begin
          if (m_ras.size() == 0) set = 1'b1;
          else m_pc = m_ras.pop_back();
        end
`ifdef PC_REL_BRANCH_EN
        3'd4: begin
          off  = int'($signed(t));
          m_pc = 16'((int'(m_pc) + 1 + off + 65536) % 65536);
        end
`endif
        default: m_pc = 16'((int'(m_pc) + 1) % 65536);
      endcase
    end
    if (set) m_fault = 1'b1;
    else if (c) m_fault = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic [2:0] o,
                      input logic [15:0] t, input logic c);
    @(negedge clk);
    en = e; op = o; target = t; clr_fault = c;
    model_step(e, o, t, c);
    exp_q.push_back(snapshot());
    @(posedge clk);
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    en = 1'b0;
    clr_fault = 1'b0;
    #1;
    model_reset();
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_sp"}, 32'(sp), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_empty"}, 32'(stack_empty), 32'd1);
    check({tag, "_full"}, 32'(stack_full), 32'd0);
    check({tag, "_ret"}, 32'(ret_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", 32'(pc), 32'(e[37:22]));
        check("sp", 32'(sp), 32'(e[21:19]));
        check("fault", 32'(fault), 32'(e[18]));
        check("ret_addr", 32'(ret_addr), 32'(e[17:2]));
        check("stack_full", 32'(stack_full), 32'(e[1]));
        check("stack_empty", 32'(stack_empty), 32'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; op = 3'd0; target = 16'h0; clr_fault = 1'b0;
    model_reset();
    #12;
    check("reset_pc", 32'(pc), 32'(RV));
    check("reset_sp", 32'(sp), 32'd0);
    check("reset_empty", 32'(stack_empty), 32'd1);
    check("reset_full", 32'(stack_full), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_ret", 32'(ret_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // increment, hold, wrap, jump
    repeat (3) step(1'b1, 3'd0, 16'h0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b1, 3'd1, 16'hFFFF, 1'b0);
    step(1'b1, 3'd0, 16'h0, 1'b0);
    step(1'b1, 3'd1, 16'h1234, 1'b0);

    // nested call / return
    step(1'b1, 3'd1, 16'h0010, 1'b0);
    step(1'b1, 3'd2, 16'h0200, 1'b0);
    step(1'b1, 3'd2, 16'h0300, 1'b0);
    step(1'b1, 3'd3, 16'h0, 1'b0);
    step(1'b1, 3'd3, 16'h0, 1'b0);

    // fill, overflow, clear together with a pop
    for (int i = 0; i < 4; i++) step(1'b1, 3'd2, 16'(16'h0400 + i * 16'h0100), 1'b0);
    step(1'b1, 3'd2, 16'h0800, 1'b0);
    step(1'b1, 3'd3, 16'h0, 1'b1);
    repeat (3) step(1'b1, 3'd3, 16'h0, 1'b0);

    // underflow while clearing: set wins
    step(1'b1, 3'd3, 16'h0, 1'b1);
    step(1'b0, 3'd0, 16'h0, 1'b1);

    // reset mid-sequence with three entries on the stack
    repeat (3) step(1'b1, 3'd2, 16'h0A00, 1'b0);
    async_reset("rst_mid");

    // relative branch (or INC when compiled out)
    step(1'b1, 3'd1, 16'h0050, 1'b0);
    step(1'b1, 3'd4, 16'hFFF0, 1'b0);
    step(1'b1, 3'd4, 16'h0007, 1'b0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic        e;
      logic [2:0]  o;
      int          r;
      e = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 3)      o = 3'd2;
      else if (r < 6) o = 3'd3;
      else            o = 3'($urandom_range(0, 7));
      step(e, o, 16'($urandom_range(0, 65535)), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 199) == 0) async_reset("rst_rand");
    end

    @(negedge clk);
    en = 1'b0;
    clr_fault = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
